// File: rtl/rr_arbiter8.sv
// Round-robin output-port arbiter with wormhole lock: a registered one-hot grant
// is held for a whole packet, and the pointer rotates past each winner so no input starves.
module rr_arbiter8 #(
  parameter int N       = 8,
  parameter bit LOCK_EN = 1'b1
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [N-1:0] req,
  input  logic [N-1:0] release_i,
  output logic [N-1:0] grant,
  output logic         grant_valid
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {
    IDLE,
    HOLD
  } state_e;

  state_e         state_q, state_d;
  logic [PW-1:0]  ptr_q, ptr_d;
  logic [N-1:0]   grant_q, grant_d;
  logic           valid_q, valid_d;

  logic           found;
  logic [PW-1:0]  win;
  logic           hold_end;
  logic           arb;
  int             idx;

  // Circular scan starting at ptr; the first requester met wins.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = 0;
    for (int i = 0; i < N; i++) begin
      idx = int'(ptr_q) + i;
      if (idx >= N) idx = idx - N;
      if (!found && req[PW'(idx)]) begin
        found = 1'b1;
        win   = PW'(idx);
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    grant_d  = grant_q;
    hold_end = |(grant_q & (release_i | ~req));
    arb      = !LOCK_EN || (state_q == IDLE) || hold_end;

    // A finished packet re-arbitrates in the same cycle, so there is no bubble.
    if (arb) begin
      if (found) begin
        grant_d      = '0;
        grant_d[win] = 1'b1;
        ptr_d        = (win == PW'(N - 1)) ? '0 : win + 1'b1;
        state_d      = HOLD;
      end else begin
        grant_d = '0;
        state_d = IDLE;
      end
    end
    valid_d = |grant_d;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      grant_q <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      valid_q <= valid_d;
    end
  end

  assign grant       = grant_q;
  assign grant_valid = valid_q;

endmodule

// File: tb/tb_rr_arbiter8.sv
// Bench for rr_arbiter8: directed packet scenarios followed by random traffic,
// each cycle checked against a queue-free integer model of the round-robin rules.
module tb_rr_arbiter8;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [7:0] req;
  logic [7:0] rel;
  logic [7:0] grant;
  logic       grant_valid;

  int passCount  = 0;
  int checkCount = 0;

  // Model: index of the granted port (-1 for none) and the next port to favour.
  int mGrant = -1;
  int mPtr   = 0;

  rr_arbiter8 #(.N(8), .LOCK_EN(1'b1)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .req        (req),
    .release_i  (rel),
    .grant      (grant),
    .grant_valid(grant_valid)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] expGrant();
    return (mGrant < 0) ? 8'h00 : 8'(1 << mGrant);
  endfunction

  task automatic modelStep(input logic [7:0] r, input logic [7:0] rl);
    bit ended;
    ended = 1'b1;
    if (mGrant >= 0)
      ended = (((r >> mGrant) & 8'h01) == 8'h00) || (((rl >> mGrant) & 8'h01) != 8'h00);
    if (ended) begin
      mGrant = -1;
      for (int k = 0; k < 8; k++) begin
        int cand;
        cand = (mPtr + k) % 8;
        if (mGrant < 0 && (((r >> cand) & 8'h01) != 8'h00)) mGrant = cand;
      end
      if (mGrant >= 0) mPtr = (mGrant + 1) % 8;
    end
  endtask

  task automatic applyStimulus(input logic [7:0] r, input logic [7:0] rl);
    req = r;
    rel = rl;
    modelStep(r, rl);
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checkCount++;
    assert (obs === exp) passCount++;
    else $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic checkModel(input string tag);
    checkOutput(tag, grant, expGrant());
    checkOutput({tag, "_valid"}, {7'b0, grant_valid}, {7'b0, (mGrant >= 0)});
  endtask

  initial begin
    logic [7:0] r;
    logic [7:0] rl;

    reset_n = 1'b0;
    req     = 8'h00;
    rel     = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_grant", grant, 8'h00);
    checkOutput("reset_valid", {7'b0, grant_valid}, 8'h00);
    reset_n = 1'b1;

    $display("[TB] idle with no requests");
    repeat (4) begin
      applyStimulus(8'h00, 8'h00);
      checkModel("idle");
    end
    checkOutput("idle_const", grant, 8'h00);

    $display("[TB] two requesters and release handoff");
    applyStimulus(8'h81, 8'h00);
    checkModel("first_grant");
    checkOutput("first_grant_const", grant, 8'h01);
    applyStimulus(8'h81, 8'h01);
    checkOutput("handoff_to_7", grant, 8'h80);
    applyStimulus(8'h81, 8'h80);
    checkOutput("handoff_to_0", grant, 8'h01);
    checkModel("handoff_model");

    $display("[TB] full round robin with single-flit packets");
    for (int k = 0; k < 8; k++) begin
      applyStimulus(8'hFF, expGrant());
      checkModel("rr_model");
      checkOutput("rr_seq", grant, 8'(1 << ((k + 1) % 8)));
    end

    $display("[TB] wormhole lock");
    applyStimulus(8'h06, 8'h00);
    checkOutput("lock_start", grant, 8'h02);
    repeat (5) begin
      applyStimulus(8'h06, 8'h00);
      checkModel("lock_hold");
    end
    checkOutput("lock_held", grant, 8'h02);
    applyStimulus(8'h06, 8'h04);
    checkOutput("foreign_release", grant, 8'h02);
    applyStimulus(8'h06, 8'h02);
    checkOutput("own_release", grant, 8'h04);

    $display("[TB] request drop");
    applyStimulus(8'h0C, 8'h00);
    checkOutput("drop_pre", grant, 8'h04);
    applyStimulus(8'h08, 8'h00);
    checkOutput("drop_switch", grant, 8'h08);
    applyStimulus(8'h00, 8'h00);
    checkOutput("drop_idle", grant, 8'h00);
    checkModel("drop_model");
    applyStimulus(8'h00, 8'h08);
    checkOutput("idle_release", grant, 8'h00);

    $display("[TB] mid-packet reset");
    applyStimulus(8'h20, 8'h00);
    checkOutput("pre_reset", grant, 8'h20);
    #2;
    reset_n = 1'b0;
    mGrant  = -1;
    mPtr    = 0;
    #1;
    checkOutput("async_reset_grant", grant, 8'h00);
    checkOutput("async_reset_valid", {7'b0, grant_valid}, 8'h00);
    req = 8'h21;
    @(posedge clk);
    #1;
    checkOutput("reset_held", grant, 8'h00);
    reset_n = 1'b1;
    applyStimulus(8'h21, 8'h00);
    checkOutput("post_reset_ptr0", grant, 8'h01);
    checkModel("post_reset_model");

    $display("[TB] random traffic");
    for (int n = 0; n < 400; n++) begin
      r = 8'($urandom);
      if ($urandom_range(0, 3) == 0) r = r & 8'($urandom);
      if ($urandom_range(0, 2) == 0) rl = expGrant() | (8'($urandom) & 8'($urandom) & 8'($urandom));
      else rl = 8'($urandom) & 8'($urandom) & 8'($urandom);
      applyStimulus(r, rl);
      checkModel("rand");
      checkOutput("rand_onehot", {7'b0, ($countones(grant) <= 1)}, 8'h01);
      checkOutput("rand_subset", grant & ~r, 8'h00);
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
